// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef logic [31:0] instruction_type;

  localparam instruction_type NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    instruction_type instr;
    logic [31:0]     pc;
  } fetch_entry_type;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} entries between imem responses and decode.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  fetch_entry_type push_entry,
  input  logic            pop,
  input  logic            flush,
  output fetch_entry_type head,
  output logic            empty,
  output logic [AW:0]     count
);

  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  // Extra MSB on each pointer separates full from empty.
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  fetch_entry_type mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem reads, buffers responses for decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [31:0]     imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            out_valid,
  output instruction_type out_instruction,
  output logic [31:0]     out_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_empty, fifo_push, fifo_pop, req_fire;
  logic [31:0]     redirect_aligned;
  fetch_entry_type fifo_head, push_entry;
  logic            unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];
  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};

  // Buffered plus outstanding words may never exceed the FIFO, so a push always has room.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < DepthW);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fifo_push  = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign fifo_pop   = !fifo_empty && !stall && !redirect_valid;
  assign push_entry = '{instr: imem_resp_data, pc: resp_pc_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      // Every response still owed belongs to the old path; one arriving now is already gone.
      inflight_d = inflight_q - CW'(imem_resp_valid);
      drop_cnt_d = inflight_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (fifo_push) resp_pc_d = resp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= ResetPcAligned;
      resp_pc_q  <= ResetPcAligned;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign out_valid       = !fifo_empty;
  assign out_instruction = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign out_pc          = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model returning addr-as-data plus a decode-side scoreboard.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic            clk, reset;
  logic            imem_req_valid, imem_req_ready;
  logic [31:0]     imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            stall, redirect_valid;
  logic [31:0]     redirect_pc;
  logic            out_valid;
  instruction_type out_instruction;
  logic [31:0]     out_pc;

  fetch_stage #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend[$];     // accepted requests awaiting a response
  logic [31:0] exp_out[$];  // pcs decode should see, in order
  logic [31:0] exp_addr;
  int compared = 0, mismatched = 0;
  int cyc = 0, lat_min = 0, lat_max = 0;
  int first_valid_cyc = -1, rel_cyc = 0;
  logic        last_ov, last_req_valid;
  logic [31:0] last_opc, last_req_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive memory response, check outputs mid-cycle, advance the model after the edge.
  task automatic step();
    logic exp_rv, fire;
    pend_t e;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend[0].addr;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #2;
    exp_rv = !redirect_valid && (exp_out.size() + pend.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_addr);
    chk("credit", 32'(exp_out.size() + pend.size() <= DEPTH), 32'd1);
    chk("out_valid", 32'(out_valid), 32'(exp_out.size() > 0));
    if (exp_out.size() > 0) begin
      chk("out_pc", out_pc, exp_out[0]);
      chk("out_instr", out_instruction, exp_out[0]);
    end else begin
      chk("idle_pc", out_pc, 32'h0);
      chk("idle_instr", out_instruction, NOP_INSTR);
    end
    last_ov        = out_valid;
    last_opc       = out_pc;
    last_req_valid = imem_req_valid;
    last_req_addr  = imem_req_addr;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    fire = imem_req_valid && imem_req_ready;
    @(posedge clk);
    #1;
    if (!redirect_valid && !stall && exp_out.size() > 0) void'(exp_out.pop_front());
    if (imem_resp_valid) begin
      e = pend.pop_front();
      if (!e.stale && !redirect_valid) exp_out.push_back(e.addr);
    end
    if (redirect_valid) begin
      exp_out.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_addr = {redirect_pc[31:2], 2'b00};
    end else if (fire) begin
      pend.push_back('{addr: exp_addr, due: cyc + 1 + int'($urandom_range(lat_max, lat_min)),
                       stale: 1'b0});
      exp_addr = exp_addr + 32'd4;
    end
    cyc++;
  endtask

  task automatic wait_first(input string tag, input logic [31:0] target);
    last_ov = 1'b0;
    for (int i = 0; i < 20 && !last_ov; i++) step();
    chk({tag, "_seen"}, 32'(last_ov), 32'd1);
    chk({tag, "_pc"}, last_opc, target);
  endtask

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    exp_addr = RST_PC;
    @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instruction, NOP_INSTR);
    chk("rst_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Zero-wait memory, always ready: one word per cycle, first out two cycles after release.
    imem_req_ready = 1'b1;
    rel_cyc = cyc;
    repeat (12) step();
    chk("first_valid_lat", 32'(first_valid_cyc - rel_cyc), 32'd2);

    // Stall long enough to exhaust credit, then drain.
    stall = 1'b1;
    repeat (10) step();
    chk("stall_req_off", 32'(last_req_valid), 32'd0);
    stall = 1'b0;
    repeat (8) step();

    // Redirect with responses still in flight.
    lat_min = 1;
    lat_max = 1;
    repeat (6) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    wait_first("redir", 32'h0000_0100);
    repeat (3) step();

    // Unaligned redirect coincident with a response and a stall.
    for (int i = 0; i < 20; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc) break;
      step();
    end
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    step();
    chk("coinc_addr", last_req_addr, 32'h0000_0100);
    chk("coinc_req_valid", 32'(last_req_valid), 32'd1);
    chk("coinc_empty", 32'(last_ov), 32'd0);
    stall = 1'b0;
    wait_first("coinc", 32'h0000_0100);

    // Random ready, stall, latency and occasional redirects.
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 2000; i++) begin
      imem_req_ready = 1'($urandom_range(1, 0));
      stall = ($urandom_range(3, 0) == 0);
      redirect_valid = ($urandom_range(49, 0) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset between edges with a full FIFO.
    imem_req_ready = 1'b1;
    stall = 1'b1;
    repeat (8) step();
    #3;
    reset = 1'b1;
    imem_resp_valid = 1'b0;
    #1;
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_instr", out_instruction, NOP_INSTR);
    chk("arst_pc", out_pc, 32'h0);
    pend.delete();
    exp_out.delete();
    exp_addr = RST_PC;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    wait_first("restart", RST_PC);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
